// File: rtl/rle_pkg.sv
// Shared constants for the run-length tokeniser: word layout and run-length limits.
// Output word layout is {eof, eol, value, length}, with length occupying the low bits.
package rle_pkg;

    localparam int DEF_LEN_W = 11;

    // Field offsets for the default length width; wider or narrower words keep the same order.
    localparam int LEN_LSB = 0;
    localparam int VAL_BIT = DEF_LEN_W;
    localparam int EOL_BIT = DEF_LEN_W + 1;
    localparam int EOF_BIT = DEF_LEN_W + 2;

    function automatic int max_len(input int len_w);
        return (1 << len_w) - 1;
    endfunction

    localparam int MAX_LEN = max_len(DEF_LEN_W);

    typedef enum logic {
        RUN_IDLE   = 1'b0,
        RUN_ACTIVE = 1'b1
    } run_state_e;

endpackage

// File: rtl/rle_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered read port.
// The head word is kept in a register, so nothing combinational leads from pop to the outputs.
module rle_sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             do_pop;
    logic             do_push;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign do_pop    = pop_i & ~empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push   = push_i & (~full_o | do_pop);
    assign rd_ptr_d  = rd_ptr_q + AW'(do_pop);
    assign rd_data_o = rd_data_q;
    assign level_o   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
            // Bypass when the word being written becomes the new head.
            if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                rd_data_q <= wr_data_i;
            end else begin
                rd_data_q <= mem_q[rd_ptr_d];
            end
        end
    end

endmodule

// File: rtl/rle_run_fifo.sv
// Run-length tokeniser for the binarised pixel stream, buffering {eof, eol, value, length}
// words in a FWFT FIFO drained by a ready/valid consumer.
module rle_run_fifo
    import rle_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int DEPTH = 64
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     bit_in,
    input  logic                     eol,
    input  logic                     eof,
    output logic [LEN_W+2:0]         out_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int               WORD_W  = LEN_W + 3;
    localparam logic [LEN_W-1:0] MAX_RUN = LEN_W'(max_len(LEN_W));
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    run_state_e        state_q, state_d;
    logic              cur_val_q, cur_val_d;
    logic [LEN_W-1:0]  cur_len_q, cur_len_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              overflow_q;
    logic              push;
    logic [WORD_W-1:0] push_word;
    logic              line_end;
    logic              extend;
    logic              fifo_full;
    logic              fifo_empty;

    function automatic logic [WORD_W-1:0] pack(input logic f_eof, input logic f_eol,
                                               input logic f_val, input logic [LEN_W-1:0] f_len);
        logic [WORD_W-1:0] w;
        w = '0;
        w[LEN_W + (EOF_BIT - VAL_BIT)] = f_eof;
        w[LEN_W + (EOL_BIT - VAL_BIT)] = f_eol;
        w[LEN_W]                       = f_val;
        w[LEN_LSB +: LEN_W]            = f_len;
        return w;
    endfunction

    assign line_end = eol | eof;
    assign extend   = (state_q == RUN_ACTIVE) && (bit_in == cur_val_q) && (cur_len_q != MAX_RUN);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= RUN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            state_d = line_end ? RUN_IDLE : RUN_ACTIVE;
        end
    end

    // A line-end pixel that also closes the previous run parks its own one-pixel run in hold.
    always_comb begin
        push         = hold_valid_q;
        push_word    = hold_q;
        cur_val_d    = cur_val_q;
        cur_len_d    = cur_len_q;
        hold_d       = hold_q;
        hold_valid_d = 1'b0;
        if (enable) begin
            if (state_q == RUN_IDLE) begin
                cur_val_d = bit_in;
                cur_len_d = ONE;
                if (line_end) begin
                    push      = 1'b1;
                    push_word = pack(eof, 1'b1, bit_in, ONE);
                end
            end else if (extend) begin
                cur_len_d = cur_len_q + ONE;
                if (line_end) begin
                    push      = 1'b1;
                    push_word = pack(eof, 1'b1, cur_val_q, cur_len_q + ONE);
                end
            end else begin
                push      = 1'b1;
                push_word = pack(1'b0, 1'b0, cur_val_q, cur_len_q);
                cur_val_d = bit_in;
                cur_len_d = ONE;
                if (line_end) begin
                    hold_d       = pack(eof, 1'b1, bit_in, ONE);
                    hold_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cur_val_q    <= 1'b0;
            cur_len_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cur_val_q    <= cur_val_d;
            cur_len_q    <= cur_len_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            if (push && fifo_full && !(out_valid && out_ready)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    rle_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .srst      (reset),
        .push_i    (push),
        .wr_data_i (push_word),
        .pop_i     (out_ready),
        .rd_data_o (out_word),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (level)
    );

    assign out_valid = ~fifo_empty;
    assign overflow  = overflow_q;

endmodule
